// File: rtl/ysyx_22040632_ifu_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22040632_ifu_pkg
// Shared definitions for the instruction fetch unit: the fetch state
// encoding and the default address/instruction widths and reset PC.
// ----------------------------------------------------------------------------
package ysyx_22040632_ifu_pkg;

   localparam int          IFU_XLEN     = 64;
   localparam int          IFU_ILEN     = 32;
   localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

   // REQ  : request presented to instruction memory
   // WAIT : request accepted, waiting for the single response
   // HOLD : instruction held for decode until accepted
   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_e;

endpackage : ysyx_22040632_ifu_pkg

// File: rtl/ysyx_22040632_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_22040632_ifu
// Instruction fetch unit in front of decode. Owns the architectural fetch PC,
// keeps at most one request outstanding to instruction memory, holds the
// returned instruction and its PC until decode takes them, and applies
// jal/jalr redirects from execute, discarding stale in-flight responses.
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   imem_req_valid    : fetch request valid (registered)
//   imem_req_ready    : memory accepts the request this cycle
//   imem_req_addr     : fetch address
//   imem_rsp_valid    : response valid, one per accepted request
//   imem_rsp_data     : fetched instruction
//   redirect_valid    : single-cycle control-flow redirect
//   redirect_pc       : redirect target (no alignment check)
//   inst_valid        : instruction/PC valid toward decode
//   inst_ready        : decode accepts the instruction
//   inst, pc          : instruction and its PC
// ----------------------------------------------------------------------------
module ysyx_22040632_ifu
   import ysyx_22040632_ifu_pkg::*;
#(
   parameter int               XLEN     = IFU_XLEN,
   parameter int               ILEN     = IFU_ILEN,
   parameter logic [XLEN-1:0]  RESET_PC = IFU_RESET_PC[XLEN-1:0]
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [ILEN-1:0] inst,
   output logic [XLEN-1:0] pc
);

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   fetch_state_e    r_state,      w_state_nxt;
   logic [XLEN-1:0] r_fetch_pc,   w_fetch_pc_nxt;
   logic            r_kill,       w_kill_nxt;
   logic            r_inst_valid, w_inst_valid_nxt;
   logic [ILEN-1:0] r_inst,       w_inst_nxt;
   logic [XLEN-1:0] r_pc,         w_pc_nxt;
   logic            r_req_valid;
   logic            w_req_fire;

   // r_req_valid is only ever set when the next state is REQ, so it alone
   // qualifies the handshake; it also keeps the request low for the cycle
   // right after reset.
   assign w_req_fire = r_req_valid & imem_req_ready;

   always_comb begin
      w_state_nxt      = r_state;
      w_fetch_pc_nxt   = r_fetch_pc;
      w_kill_nxt       = r_kill;
      w_inst_valid_nxt = r_inst_valid;
      w_inst_nxt       = r_inst;
      w_pc_nxt         = r_pc;
      unique case (r_state)
         ST_REQ: begin
            if (redirect_valid) begin
               w_fetch_pc_nxt = redirect_pc;
            end
            if (w_req_fire) begin
               w_state_nxt = ST_WAIT;
               // The accepted address is already stale if a redirect lands
               // in the same cycle; mark its response for discard.
               w_kill_nxt  = redirect_valid;
            end
         end
         ST_WAIT: begin
            if (imem_rsp_valid) begin
               if (redirect_valid || r_kill) begin
                  if (redirect_valid) begin
                     w_fetch_pc_nxt = redirect_pc;
                  end
                  w_kill_nxt  = 1'b0;
                  w_state_nxt = ST_REQ;
               end else begin
                  w_inst_nxt       = imem_rsp_data;
                  w_pc_nxt         = r_fetch_pc;
                  w_inst_valid_nxt = 1'b1;
                  w_state_nxt      = ST_HOLD;
               end
            end else if (redirect_valid) begin
               w_kill_nxt     = 1'b1;
               w_fetch_pc_nxt = redirect_pc;
            end
         end
         ST_HOLD: begin
            // A redirect wins over the sequential PC even when decode accepts
            // in the same cycle.
            if (redirect_valid) begin
               w_inst_valid_nxt = 1'b0;
               w_fetch_pc_nxt   = redirect_pc;
               w_state_nxt      = ST_REQ;
            end else if (inst_ready) begin
               w_inst_valid_nxt = 1'b0;
               w_fetch_pc_nxt   = r_fetch_pc + PC_STEP;
               w_state_nxt      = ST_REQ;
            end
         end
         default: begin
            w_state_nxt = ST_REQ;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_REQ;
         r_fetch_pc   <= RESET_PC;
         r_kill       <= 1'b0;
         r_inst_valid <= 1'b0;
         r_inst       <= '0;
         r_pc         <= '0;
         r_req_valid  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_fetch_pc   <= w_fetch_pc_nxt;
         r_kill       <= w_kill_nxt;
         r_inst_valid <= w_inst_valid_nxt;
         r_inst       <= w_inst_nxt;
         r_pc         <= w_pc_nxt;
         r_req_valid  <= (w_state_nxt == ST_REQ);
      end
   end

   // A response is only legal while a request is outstanding.
   always_ff @(posedge clk) begin
      if (!rst && imem_rsp_valid) begin
         assert (r_state == ST_WAIT)
            else $error("imem_rsp_valid asserted outside WAIT");
      end
   end

   assign imem_req_valid = r_req_valid;
   assign imem_req_addr  = r_fetch_pc;
   assign inst_valid     = r_inst_valid;
   assign inst           = r_inst;
   assign pc             = r_pc;

endmodule : ysyx_22040632_ifu

// File: tb/tb_ysyx_22040632_ifu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22040632_ifu
// Directed bench for the fetch unit. Inputs are driven and outputs sampled
// on the falling clock edge; the memory and decode sides are driven by hand.
// ----------------------------------------------------------------------------
module tb_ysyx_22040632_ifu;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] pc;

   int checks = 0;
   int errors = 0;

   ysyx_22040632_ifu dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .pc             (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      inst_ready     = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();

      // Reset state
      tick(); tick();
      check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
      check("rst_req_addr",  imem_req_addr, 64'h8000_0000);
      check("rst_inst_valid",{63'd0, inst_valid}, 64'd0);
      check("rst_inst",      {32'd0, inst}, 64'd0);
      check("rst_pc",        pc, 64'd0);
      rst = 1'b0;

      // First fetch with a one-cycle memory
      tick();
      check("f1_req_valid", {63'd0, imem_req_valid}, 64'd1);
      check("f1_req_addr",  imem_req_addr, 64'h8000_0000);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      check("f1_wait_req_valid", {63'd0, imem_req_valid}, 64'd0);
      check("f1_wait_inst_valid", {63'd0, inst_valid}, 64'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0000_0413;
      tick();
      imem_rsp_valid = 1'b0;
      check("f1_inst_valid", {63'd0, inst_valid}, 64'd1);
      check("f1_inst",       {32'd0, inst}, 64'h0000_0413);
      check("f1_pc",         pc, 64'h8000_0000);

      // Decode stalls for five cycles
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_inst_valid", {63'd0, inst_valid}, 64'd1);
         check("stall_inst",       {32'd0, inst}, 64'h0000_0413);
         check("stall_pc",         pc, 64'h8000_0000);
         check("stall_no_req",     {63'd0, imem_req_valid}, 64'd0);
      end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      check("acc_inst_valid", {63'd0, inst_valid}, 64'd0);
      check("acc_req_valid",  {63'd0, imem_req_valid}, 64'd1);
      check("acc_req_addr",   imem_req_addr, 64'h8000_0004);

      // Redirect while waiting: stale response dropped
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0100;
      tick();
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      tick();
      imem_rsp_valid = 1'b0;
      check("rw_drop_inst_valid", {63'd0, inst_valid}, 64'd0);
      check("rw_req_valid",       {63'd0, imem_req_valid}, 64'd1);
      check("rw_req_addr",        imem_req_addr, 64'h8000_0100);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0010_0093;
      tick();
      imem_rsp_valid = 1'b0;
      check("rw_inst_valid", {63'd0, inst_valid}, 64'd1);
      check("rw_inst",       {32'd0, inst}, 64'h0010_0093);
      check("rw_pc",         pc, 64'h8000_0100);

      // Redirect coincident with accept in HOLD
      inst_ready     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0200;
      tick();
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      check("rh_inst_valid", {63'd0, inst_valid}, 64'd0);
      check("rh_req_valid",  {63'd0, imem_req_valid}, 64'd1);
      check("rh_req_addr",   imem_req_addr, 64'h8000_0200);

      // Redirect in REQ without handshake, then accepted: no kill
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0300;
      tick();
      redirect_valid = 1'b0;
      check("rr_req_valid", {63'd0, imem_req_valid}, 64'd1);
      check("rr_req_addr",  imem_req_addr, 64'h8000_0300);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0000_0013;
      tick();
      imem_rsp_valid = 1'b0;
      check("rr_inst_valid", {63'd0, inst_valid}, 64'd1);
      check("rr_pc",         pc, 64'h8000_0300);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      check("rr_next_addr", imem_req_addr, 64'h8000_0304);

      // Redirect coincident with request handshake: response killed
      imem_req_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0400;
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b0;
      check("rk_wait_req_valid", {63'd0, imem_req_valid}, 64'd0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0BAD_0BAD;
      tick();
      imem_rsp_valid = 1'b0;
      check("rk_inst_valid", {63'd0, inst_valid}, 64'd0);
      check("rk_req_valid",  {63'd0, imem_req_valid}, 64'd1);
      check("rk_req_addr",   imem_req_addr, 64'h8000_0400);

      // Redirect coincident with response, unaligned target passed through
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h1111_1111;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0502;
      tick();
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      check("rc_inst_valid", {63'd0, inst_valid}, 64'd0);
      check("rc_req_valid",  {63'd0, imem_req_valid}, 64'd1);
      check("rc_req_addr",   imem_req_addr, 64'h8000_0502);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0000_0093;
      tick();
      imem_rsp_valid = 1'b0;
      check("rc_inst_valid2", {63'd0, inst_valid}, 64'd1);
      check("rc_pc",          pc, 64'h8000_0502);

      // Reset while waiting
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      check("rs_pre_addr", imem_req_addr, 64'h8000_0506);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      rst = 1'b1;
      tick();
      check("rs_req_valid",  {63'd0, imem_req_valid}, 64'd0);
      check("rs_req_addr",   imem_req_addr, 64'h8000_0000);
      check("rs_inst_valid", {63'd0, inst_valid}, 64'd0);
      check("rs_inst",       {32'd0, inst}, 64'd0);
      check("rs_pc",         pc, 64'd0);
      rst = 1'b0;
      tick();
      check("rs_restart_valid", {63'd0, imem_req_valid}, 64'd1);
      check("rs_restart_addr",  imem_req_addr, 64'h8000_0000);

      // PC wrap from the top of the address space
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      check("wr_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0000_006F;
      tick();
      imem_rsp_valid = 1'b0;
      check("wr_inst_valid", {63'd0, inst_valid}, 64'd1);
      check("wr_pc",         pc, 64'hFFFF_FFFF_FFFF_FFFC);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      check("wr_req_valid", {63'd0, imem_req_valid}, 64'd1);
      check("wr_next_addr", imem_req_addr, 64'd0);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_ysyx_22040632_ifu
